// File: rtl/pci_par_if.sv
// PCI parity unit signal bundle: generate side, check side, error drive and status.
interface pci_par_if #(
  parameter int DW    = 32,
  parameter int CNT_W = 8
);
  // generate side
  logic              ad_oe;
  logic              oe64;
  logic [DW-1:0]     ado;
  logic [DW/8-1:0]   cbeo;
  logic              par_o;
  logic              par_oe;
  logic              par64_o;
  logic              par64_oe;
  // check side
  logic [DW-1:0]     adi;
  logic [DW/8-1:0]   cbei;
  logic              pari;
  logic              par64i;
  logic              chk_addr;
  logic              chk_data;
  logic              chk64;
  // config / error reporting
  logic              perr_en;
  logic              serr_en;
  logic              perr_o;
  logic              perr_oe;
  logic              serr_o;
  logic              stat_clr;
  logic              cnt_clr;
  logic              dpe_stat;
  logic [CNT_W-1:0]  err_cnt;

  // parity unit side
  modport slave (
    input  ad_oe, oe64, ado, cbeo, adi, cbei, pari, par64i,
           chk_addr, chk_data, chk64, perr_en, serr_en, stat_clr, cnt_clr,
    output par_o, par_oe, par64_o, par64_oe, perr_o, perr_oe, serr_o,
           dpe_stat, err_cnt
  );

  // IO flop / state machine side
  modport master (
    output ad_oe, oe64, ado, cbeo, adi, cbei, pari, par64i,
           chk_addr, chk_data, chk64, perr_en, serr_en, stat_clr, cnt_clr,
    input  par_o, par_oe, par64_o, par64_oe, perr_o, perr_oe, serr_o,
           dpe_stat, err_cnt
  );
endinterface

// File: rtl/pci_par_unit.sv
// PCI parity unit: PAR/PAR64 generation, two-stage received parity check,
// PERR#/SERR# drive controls, sticky detected-parity-error and error counter.
module pci_par_unit #(
  parameter int DW    = 32,
  parameter int CNT_W = 8
) (
  input  logic      clk,
  input  logic      rst,
  pci_par_if.slave  bus
);

  // even parity over lower/upper lanes, both for driven and received phases
  logic gen_lo, gen_hi, gen_hi_en;
  logic calc_lo, calc_hi, chk64_en;

  assign gen_lo  = ^{bus.ado[31:0], bus.cbeo[3:0]};
  assign calc_lo = ^{bus.adi[31:0], bus.cbei[3:0]};

  generate
    if (DW == 64) begin : g_w64
      assign gen_hi    = ^{bus.ado[DW-1:32], bus.cbeo[DW/8-1:4]};
      assign calc_hi   = ^{bus.adi[DW-1:32], bus.cbei[DW/8-1:4]};
      assign gen_hi_en = bus.ad_oe & bus.oe64;
      assign chk64_en  = bus.chk64;
    end else begin : g_w32
      // upper-lane controls have no meaning on a 32-bit bus
      logic unused_hi;
      assign unused_hi = ^{bus.oe64, bus.chk64, bus.par64i};
      assign gen_hi    = 1'b0;
      assign calc_hi   = 1'b0;
      assign gen_hi_en = 1'b0;
      assign chk64_en  = 1'b0;
    end
  endgenerate

  // state
  logic             par_q, par_d, par_oe_q, par_oe_d;
  logic             par64_q, par64_d, par64_oe_q, par64_oe_d;
  logic             clo_q, clo_d, chi_q, chi_d;
  logic             caddr_q, caddr_d, cdata_q, cdata_d, c64_q, c64_d;
  logic             perr_q, perr_d, perr_oe_q, perr_oe_d, serr_q, serr_d;
  logic             dpe_q, dpe_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // stage-2 error terms: received PAR arrives one clock after its phase
  logic err_lo, err_hi, par_err, data_err, addr_err;

  assign err_lo   = clo_q ^ bus.pari;
  assign err_hi   = c64_q & (chi_q ^ bus.par64i);
  assign par_err  = err_lo | err_hi;
  assign data_err = cdata_q & par_err;
  // a phase flagged both address and data is treated as data only
  assign addr_err = caddr_q & ~cdata_q & par_err;

  // next-state for generate path, check pipeline and error reporting
  always_comb begin
    par_d      = bus.ad_oe ? gen_lo : par_q;
    par_oe_d   = bus.ad_oe;
    par64_d    = gen_hi_en ? gen_hi : par64_q;
    par64_oe_d = gen_hi_en;

    clo_d   = calc_lo;
    chi_d   = calc_hi;
    caddr_d = bus.chk_addr;
    cdata_d = bus.chk_data;
    c64_d   = chk64_en;

    perr_d    = data_err & bus.perr_en;
    // hold the enable one cycle past the last error so PERR# is driven high before release
    perr_oe_d = perr_d | perr_q;
    serr_d    = addr_err & bus.perr_en & bus.serr_en;

    dpe_d = dpe_q;
    if (bus.stat_clr) dpe_d = 1'b0;
    if (par_err & (cdata_q | caddr_q)) dpe_d = 1'b1;

    cnt_d = cnt_q;
    if (bus.cnt_clr) cnt_d = '0;
    if (data_err | addr_err) begin
      if (bus.cnt_clr)       cnt_d = CNT_W'(1);
      else if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // all state registers, cleared asynchronously so no pending error survives reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_q      <= 1'b0;
      par_oe_q   <= 1'b0;
      par64_q    <= 1'b0;
      par64_oe_q <= 1'b0;
      clo_q      <= 1'b0;
      chi_q      <= 1'b0;
      caddr_q    <= 1'b0;
      cdata_q    <= 1'b0;
      c64_q      <= 1'b0;
      perr_q     <= 1'b0;
      perr_oe_q  <= 1'b0;
      serr_q     <= 1'b0;
      dpe_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      par_q      <= par_d;
      par_oe_q   <= par_oe_d;
      par64_q    <= par64_d;
      par64_oe_q <= par64_oe_d;
      clo_q      <= clo_d;
      chi_q      <= chi_d;
      caddr_q    <= caddr_d;
      cdata_q    <= cdata_d;
      c64_q      <= c64_d;
      perr_q     <= perr_d;
      perr_oe_q  <= perr_oe_d;
      serr_q     <= serr_d;
      dpe_q      <= dpe_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.par_o    = par_q;
  assign bus.par_oe   = par_oe_q;
  assign bus.par64_o  = par64_q;
  assign bus.par64_oe = par64_oe_q;
  assign bus.perr_o   = perr_q;
  assign bus.perr_oe  = perr_oe_q;
  assign bus.serr_o   = serr_q;
  assign bus.dpe_stat = dpe_q;
  assign bus.err_cnt  = cnt_q;

endmodule
